// File: rtl/multiword_adder_seq_pkg.sv
// multiword_adder_seq_pkg: shared FSM encoding and slice width for the multiword adder
package multiword_adder_seq_pkg;
  localparam int SLICE_W = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/multiword_adder_seq_adder.sv
// adder: 16-bit combinational slice adder with carry in/out
module adder
  import multiword_adder_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);
  assign {cout_o, sum_o} = (SLICE_W+1)'(a_i) + (SLICE_W+1)'(b_i) + (SLICE_W+1)'(cin_i);
endmodule

// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq: WORDS x 16-bit add/sub computed one slice per cycle, LSB first
module multiword_adder_seq
  import multiword_adder_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op_sub,
  input  logic                     cin,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] result,
  output logic                     cout,
  output logic                     ovf
);
  localparam int KW = $clog2(WORDS);
  state_e                          state_q, state_d;
  logic [KW-1:0]                   k_q, k_d;
  logic                            carry_q, carry_d;
  logic [WORDS-1:0][SLICE_W-1:0]   opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic                            cout_q, cout_d, ovf_q, ovf_d;
  logic [SLICE_W-1:0]              sum;
  logic                            co;
  logic                            last;
  adder u_adder (
    .a_i   (opa_q[k_q]),
    .b_i   (opb_q[k_q]),
    .cin_i (carry_q),
    .sum_o (sum),
    .cout_o(co)
  );
  assign last      = k_q == KW'(WORDS-1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  // next state: latch operands in IDLE, one slice per RUN cycle, hold result in DONE
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (state_q == IDLE && in_valid) begin
      opa_d   = a;
      opb_d   = op_sub ? ~b : b;
      carry_d = op_sub | cin;
      k_d     = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      result_d[k_q] = sum;
      carry_d       = co;
      k_d           = last ? k_q : k_q + 1'b1;
      state_d       = last ? DONE : RUN;
      cout_d        = last ? co : cout_q;
      ovf_d         = last ? (opa_q[WORDS-1][SLICE_W-1] == opb_q[WORDS-1][SLICE_W-1]) &&
                             (sum[SLICE_W-1] != opa_q[WORDS-1][SLICE_W-1]) : ovf_q;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_multiword_adder_seq.sv
// tb_multiword_adder_seq: directed self-checking bench for the 4-word sequential adder
module tb_multiword_adder_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic        cin = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        cout;
  logic        ovf;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_last = 0;
  int          acc_prev = 0;
  int          n;

  multiword_adder_seq #(.WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) begin
      acc_prev <= acc_last;
      acc_last <= cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic s, input logic c);
    a = av;
    b = bv;
    op_sub = s;
    cin = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      step();
      cnt++;
    end
    chk("wait_out_valid", 64'(out_valid), 64'd1);
  endtask

  initial begin
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    step();

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_valid(n);
    chk("t1_latency", 64'(n + 1), 64'd5);
    chk("t1_result", result, 64'd0);
    chk("t1_cout", 64'(cout), 64'd1);
    chk("t1_ovf", 64'(ovf), 64'd0);
    step();
    chk("t1_back_idle", 64'(in_ready), 64'd1);

    issue(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
    wait_valid(n);
    chk("t2_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("t2_cout", 64'(cout), 64'd1);
    chk("t2_ovf", 64'(ovf), 64'd1);
    step();

    issue(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b1);
    wait_valid(n);
    chk("t3_result", result, 64'h0001_0000_0001_0001);
    chk("t3_cout", 64'(cout), 64'd0);
    chk("t3_ovf", 64'(ovf), 64'd0);
    step();

    out_ready = 1'b0;
    issue(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    wait_valid(n);
    a = 64'd5;
    b = 64'd3;
    op_sub = 1'b0;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_result", result, 64'h1234_5678_9ABC_DF00);
      chk("bp_cout", 64'(cout), 64'd0);
      chk("bp_ovf", 64'(ovf), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_hs_in_ready", 64'(in_ready), 64'd1);
    chk("bp_hs_out_valid", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    chk("bp_accept", 64'(in_ready), 64'd0);
    wait_valid(n);
    chk("bp_new_result", result, 64'd8);
    step();

    issue(64'h1111_2222_3333_4444, 64'd1, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_cout", 64'(cout), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    issue(64'd5, 64'd3, 1'b0, 1'b0);
    wait_valid(n);
    chk("post_rst_result", result, 64'd8);
    step();

    a = 64'd100;
    b = 64'd23;
    op_sub = 1'b0;
    cin = 1'b0;
    in_valid = 1'b1;
    step();
    a = 64'h0000_0000_0000_FFFF;
    b = 64'd1;
    wait_valid(n);
    chk("b2b_first", result, 64'd123);
    step();
    step();
    in_valid = 1'b0;
    chk("b2b_spacing", 64'(acc_last - acc_prev), 64'd6);
    wait_valid(n);
    chk("b2b_second", result, 64'h0000_0000_0001_0000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
